gate_model_bist: RTL and testbench

- Parametrised built-in self-test wrapper for the combinational gate-model netlists in the gate library (20-in/10-out today, any width here).
- Generates pseudo-random input patterns with an LFSR and drives them onto the netlist inputs.
- Compacts the netlist outputs into a MISR signature and compares it against an expected value.
- Sits between the simulator test harness and one gate model; turns a static netlist into a self-checking, clocked test unit.

---
 rtl/gate_model_bist_if.sv | 30 +++
 rtl/gate_model_bist.sv | 96 +++++++++
 tb/tb_gate_model_bist.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_model_bist_if.sv
// Harness-side bus of the gate-model BIST wrapper: run control, golden signature,
// netlist pattern/response pair and status.
interface gate_model_bist_if #(
  parameter int N_IN   = 20,
  parameter int N_OUT  = 10,
  parameter int MISR_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [N_IN-1:0]   seed;
  logic [CNT_W-1:0]  pat_count;
  logic [MISR_W-1:0] expected;
  logic [N_IN-1:0]   dut_in;
  logic [N_OUT-1:0]  dut_out;
  logic              busy;
  logic              done;
  logic [MISR_W-1:0] signature;
  logic              pass;

  // The master is the harness together with the netlist, which answers dut_in with dut_out.
  modport master (
    output start, seed, pat_count, expected, dut_out,
    input  dut_in, busy, done, signature, pass
  );

  modport slave (
    input  start, seed, pat_count, expected, dut_out,
    output dut_in, busy, done, signature, pass
  );
endinterface

// File: rtl/gate_model_bist.sv
// LFSR pattern generator plus MISR response compactor wrapped around one
// combinational gate-model netlist, turning it into a clocked self-checking unit.
module gate_model_bist #(
  parameter int                N_IN      = 20,
  parameter int                N_OUT     = 10,
  parameter int                MISR_W    = 16,
  parameter logic [N_IN-1:0]   LFSR_TAPS = 20'h80004,
  parameter logic [MISR_W-1:0] MISR_TAPS = 16'h8016,
  parameter int                SETTLE    = 0,
  parameter int                CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  gate_model_bist_if.slave  bist
);

  generate
    if (MISR_W < N_OUT) begin : g_badMisrWidth
      $error("gate_model_bist: MISR_W must be >= N_OUT");
    end
    if (N_IN < 2) begin : g_badLfsrWidth
      $error("gate_model_bist: N_IN must be >= 2");
    end
  endgenerate

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [N_IN-1:0]   r_lfsr;
  logic [MISR_W-1:0] r_misr;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_hold;
  logic [MISR_W-1:0] w_outExt;
  logic              w_accept;
  logic              w_capture;
  logic              w_last;

  assign w_accept  = (r_state != S_RUN) && bist.start;
  assign w_capture = (r_state == S_RUN) && (r_hold == SETTLE_L);
  assign w_last    = w_capture && (r_cnt == CNT_W'(1));

  always_comb begin
    w_outExt = '0;
    w_outExt[N_OUT-1:0] = bist.dut_out;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bist.start) w_next = (bist.pat_count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A zero seed would lock the LFSR at all-zeros, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= '0;
      r_misr <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else if (w_accept) begin
      r_lfsr <= (bist.seed == '0) ? N_IN'(1) : bist.seed;
      r_misr <= '0;
      r_cnt  <= bist.pat_count;
      r_hold <= '0;
    end else if (w_capture) begin
      r_misr <= {r_misr[MISR_W-2:0], ^(r_misr & MISR_TAPS)} ^ w_outExt;
      r_lfsr <= {r_lfsr[N_IN-2:0], ^(r_lfsr & LFSR_TAPS)};
      r_cnt  <= r_cnt - CNT_W'(1);
      r_hold <= '0;
    end else if (r_state == S_RUN) begin
      r_hold <= r_hold + 4'd1;
    end
  end

  assign bist.dut_in    = r_lfsr;
  assign bist.signature = r_misr;
  assign bist.busy      = (r_state == S_RUN);
  assign bist.done      = (r_state == S_DONE);
  assign bist.pass      = (r_state == S_DONE) && (r_misr == bist.expected);

endmodule

// File: tb/tb_gate_model_bist.sv
// Scoreboard bench: a small 4-bit BIST (SETTLE=2) and the default 20/10 BIST around a
// reference gate-model netlist, each run checked against a software LFSR/MISR model.
module tb_gate_model_bist;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_model_bist_if #(.N_IN(4), .N_OUT(4), .MISR_W(4), .CNT_W(16)) busA ();
  gate_model_bist_if busB ();

  gate_model_bist #(
    .N_IN(4), .N_OUT(4), .MISR_W(4),
    .LFSR_TAPS(4'b1001), .MISR_TAPS(4'b1001),
    .SETTLE(2), .CNT_W(16)
  ) dutA (.clk(clk), .rst(rst), .bist(busA.slave));

  gate_model_bist dutB (.clk(clk), .rst(rst), .bist(busB.slave));

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] expQ[$];

  // Reference gate model for the 20-in/10-out netlist.
  function automatic logic [9:0] netlist(input logic [19:0] x);
    logic [9:0] y;
    y = '0;
    for (int i = 0; i < 10; i++) y[i] = (x[2*i] & x[2*i+1]) ^ x[(i+7)%20] ^ x[19-i];
    return y;
  endfunction

  function automatic logic [31:0] lfsrStep(input logic [31:0] v, input int w, input logic [31:0] taps);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return ((v << 1) | {31'd0, ^(v & taps)}) & m;
  endfunction

  function automatic logic [31:0] misrStep(input logic [31:0] v, input int w, input logic [31:0] taps,
                                           input logic [31:0] d);
    logic [31:0] m;
    m = (32'd1 << w) - 32'd1;
    return (((v << 1) | {31'd0, ^(v & taps)}) ^ d) & m;
  endfunction

  logic loopA;
  assign busA.dut_out = loopA ? busA.dut_in : 4'b0000;
  always_comb busB.dut_out = netlist(busB.dut_in);

  int sel;
  logic [31:0] oDutIn, oSig;
  logic oBusy, oDone, oPass;
  always_comb begin
    if (sel == 0) begin
      oDutIn = 32'(busA.dut_in);
      oSig   = 32'(busA.signature);
      oBusy  = busA.busy;
      oDone  = busA.done;
      oPass  = busA.pass;
    end else begin
      oDutIn = 32'(busB.dut_in);
      oSig   = 32'(busB.signature);
      oBusy  = busB.busy;
      oDone  = busB.done;
      oPass  = busB.pass;
    end
  end

  task automatic driveStart(input int which, input logic s, input logic [31:0] sd, input int cnt);
    if (which == 0) begin
      busA.start = s; busA.seed = sd[3:0]; busA.pat_count = 16'(cnt);
    end else begin
      busB.start = s; busB.seed = sd[19:0]; busB.pat_count = 16'(cnt);
    end
  endtask

  task automatic setExpected(input int which, input logic [31:0] v);
    if (which == 0) busA.expected = v[3:0];
    else            busB.expected = v[15:0];
  endtask

  // Model pushes one expected dut_in per busy cycle; the DUT pops one per observed cycle.
  task automatic runScored(input int which, input logic [31:0] seedV, input int cnt, input logic loop,
                           input int pulseAt, input int abortAt, output logic [31:0] sigOut);
    int w, hold, mw, cycles, budget;
    logic [31:0] lt, mt, lv, mv, d, e;
    logic aborted;
    w    = (which != 0) ? 20 : 4;
    hold = (which != 0) ? 1 : 3;
    mw   = (which != 0) ? 16 : 4;
    lt   = (which != 0) ? 32'h80004 : 32'h9;
    mt   = (which != 0) ? 32'h8016 : 32'h9;
    lv   = seedV & ((32'd1 << w) - 32'd1);
    if (lv == 32'd0) lv = 32'd1;
    mv = 32'd0;
    expQ.delete();
    for (int p = 0; p < cnt; p++) begin
      for (int h = 0; h < hold; h++) expQ.push_back(lv);
      d  = (which != 0) ? 32'(netlist(lv[19:0])) : (loop ? lv : 32'd0);
      mv = misrStep(mv, mw, mt, d);
      lv = lfsrStep(lv, w, lt);
    end
    @(negedge clk);
    sel = which;
    if (which == 0) loopA = loop;
    driveStart(which, 1'b1, seedV, cnt);
    @(negedge clk);
    driveStart(which, 1'b0, seedV, cnt);
    cycles  = 0;
    budget  = cnt * hold + 20;
    aborted = 1'b0;
    while (oBusy && cycles < budget) begin
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("[TB] FAIL busy_overrun: busy still high after %0d cycles, required %0d", cycles, cnt * hold);
        break;
      end
      e = expQ.pop_front();
      if (oDutIn !== e) begin
        nFail++;
        $display("[TB] FAIL dut_in cycle %0d: got %h, required %h", cycles, oDutIn, e);
      end
      cycles++;
      if (cycles == abortAt) begin
        rst = 1'b1;
        @(negedge clk);
        nTests++;
        if ({oBusy, oDone, oPass} !== 3'b000 || oSig !== 32'd0 || oDutIn !== 32'd0) begin
          nFail++;
          $display("[TB] FAIL abort_reset: busy/done/pass=%b sig=%h dut_in=%h, required 000/0/0",
                   {oBusy, oDone, oPass}, oSig, oDutIn);
        end
        rst = 1'b0;
        aborted = 1'b1;
        expQ.delete();
        break;
      end
      driveStart(which, (cycles == pulseAt), seedV ^ 32'h5, 1);
      @(negedge clk);
    end
    driveStart(which, 1'b0, seedV, cnt);
    if (!aborted) begin
      nTests++;
      if (cycles != cnt * hold) begin
        nFail++;
        $display("[TB] FAIL busy_cycles: got %0d, required %0d", cycles, cnt * hold);
      end
      nTests++;
      if (oDone !== 1'b1 || oBusy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL done_rise: done=%b busy=%b, required done=1 busy=0", oDone, oBusy);
      end
      nTests++;
      if (oSig !== mv) begin
        nFail++;
        $display("[TB] FAIL signature: got %h, required %h", oSig, mv);
      end
      nTests++;
      if (expQ.size() != 0) begin
        nFail++;
        $display("[TB] FAIL pattern_count: %0d patterns never driven, required 0", expQ.size());
      end
      setExpected(which, mv);
      #1;
      nTests++;
      if (oPass !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL pass_match: got %b, required 1", oPass);
      end
      setExpected(which, mv ^ 32'd1);
      #1;
      nTests++;
      if (oPass !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL pass_mismatch: got %b, required 0", oPass);
      end
    end
    sigOut = oSig;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    driveStart(0, 1'b1, 32'h3, 2);
    driveStart(1, 1'b0, 32'h0, 0);
    setExpected(0, 32'd0);
    setExpected(1, 32'd0);
    repeat (3) @(negedge clk);
    nTests++;
    if ({busA.busy, busA.done, busA.pass} !== 3'b000 || busA.signature !== 4'd0 || busA.dut_in !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL reset_A (start held): busy/done/pass=%b sig=%h dut_in=%h, required 000/0/0",
               {busA.busy, busA.done, busA.pass}, busA.signature, busA.dut_in);
    end
    nTests++;
    if ({busB.busy, busB.done, busB.pass} !== 3'b000 || busB.signature !== 16'd0 || busB.dut_in !== 20'd0) begin
      nFail++;
      $display("[TB] FAIL reset_B: busy/done/pass=%b sig=%h dut_in=%h, required 000/0/0",
               {busB.busy, busB.done, busB.pass}, busB.signature, busB.dut_in);
    end
    driveStart(0, 1'b0, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero_seed();
    logic [31:0] s;
    runScored(0, 32'h0, 4, 1'b0, -1, -1, s);
    nTests++;
    if (s !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL zero_seed_sig: got %h, required 0", s);
    end
  endtask

  task automatic test_loopback();
    logic [31:0] s;
    runScored(0, 32'h1, 2, 1'b1, -1, -1, s);
    nTests++;
    if (s !== 32'd0) begin
      nFail++;
      $display("[TB] FAIL loopback_sig: got %h, required 0", s);
    end
  endtask

  task automatic test_latency();
    logic [31:0] s;
    runScored(0, 32'h5, 3, 1'b1, -1, -1, s);
  endtask

  task automatic test_zero_count();
    logic [31:0] s;
    runScored(0, 32'h7, 0, 1'b1, -1, -1, s);
  endtask

  task automatic test_abort();
    logic [31:0] s;
    runScored(0, 32'h9, 8, 1'b1, 2, 6, s);
    runScored(0, 32'h9, 8, 1'b1, 2, -1, s);
  endtask

  task automatic test_back_to_back();
    logic [31:0] s1, s2;
    runScored(1, 32'h00001, 1000, 1'b0, -1, -1, s1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nTests++;
      if (oDone !== 1'b1 || oSig !== s1) begin
        nFail++;
        $display("[TB] FAIL done_hold cycle %0d: done=%b sig=%h, required 1/%h", i, oDone, oSig, s1);
      end
    end
    runScored(1, 32'h00001, 1000, 1'b0, -1, -1, s2);
    nTests++;
    if (s2 !== s1) begin
      nFail++;
      $display("[TB] FAIL rerun_sig: got %h, required %h", s2, s1);
    end
  endtask

  initial begin
    sel   = 0;
    loopA = 1'b0;
    test_reset();
    test_zero_seed();
    test_loopback();
    test_latency();
    test_zero_count();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
